// File: rtl/ucaspian_pkg.sv
// rtl/ucaspian_pkg.sv - shared widths, config word layout and clear FSM states for the axon ring
package ucaspian_pkg;

    localparam int DEF_NUM_NEURONS = 256;
    localparam int DEF_SYN_W       = 12;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_DELAY_W     = 4;
    localparam int DEF_COLL_W      = 16;
    localparam int DEF_CFG_W       = DEF_DELAY_W + DEF_SYN_W + DEF_CNT_W;

    typedef struct packed {
        logic [DEF_DELAY_W-1:0] delay;
        logic [DEF_SYN_W-1:0]   first_syn;
        logic [DEF_CNT_W-1:0]   syn_count;
    } axon_cfg_t;

    typedef enum logic [1:0] {
        CLR_IDLE,
        CLR_SWEEP,
        CLR_DONE
    } clr_state_t;

endpackage

// File: rtl/ucaspian_axon_ring_ram.sv
// rtl/ucaspian_axon_ring_ram.sv - generic 1R1W synchronous RAM (read returns old data on same-address write)
module dp_ram_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/ucaspian_axon_ring.sv
// rtl/ucaspian_axon_ring.sv - maps firing neurons to synapse ranges with per-neuron delay held in a time-slot ring
module ucaspian_axon_ring
    import ucaspian_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int SYN_W       = DEF_SYN_W,
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DELAY_W     = DEF_DELAY_W,
    parameter int COLL_W      = DEF_COLL_W,
    parameter int ADDR_W      = $clog2(NUM_NEURONS)
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_enable,
    input  logic                             i_clear_act,
    input  logic                             i_clear_config,
    output logic                             o_clear_done,
    input  logic [ADDR_W-1:0]                i_config_addr,
    input  logic [DELAY_W+SYN_W+CNT_W-1:0]   i_config_data,
    input  logic                             i_config_we,
    input  logic                             i_next_step,
    output logic                             o_step_done,
    input  logic [ADDR_W-1:0]                i_axon_addr,
    input  logic                             i_axon_vld,
    output logic                             o_axon_rdy,
    output logic [SYN_W-1:0]                 o_syn_start,
    output logic [SYN_W-1:0]                 o_syn_end,
    output logic                             o_syn_vld,
    input  logic                             i_syn_rdy,
    output logic [COLL_W-1:0]                o_coll_count
);

    localparam int L_CFG_W = DELAY_W + SYN_W + CNT_W;
    localparam int D       = 1 << DELAY_W;

    logic [DELAY_W-1:0] r_tptr;
    logic [ADDR_W-1:0]  r_scan_idx;
    logic               r_scan_done;
    logic               r_p_vld;
    logic               r_p_scan;
    logic [ADDR_W-1:0]  r_p_addr;
    logic [DELAY_W-1:0] r_p_tptr;
    logic               r_q_vld;
    logic [SYN_W-1:0]   r_q_start;
    logic [SYN_W-1:0]   r_q_end;
    logic               r_wr_vld;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [D-1:0]       r_wr_data;
    clr_state_t         r_clr_state;
    logic               r_clr_cfg;
    logic [ADDR_W-1:0]  r_clr_idx;

    logic               w_ready;
    logic               w_clr_req;
    logic               w_clearing;
    logic               w_sweep;
    logic               w_spike_go;
    logic               w_scan_go;
    logic               w_issue;
    logic [ADDR_W-1:0]  w_issue_addr;
    logic [ADDR_W-1:0]  w_rd_addr;
    logic [L_CFG_W-1:0] w_cfg_rdata;
    logic [D-1:0]       w_ring_rdata;
    logic [D-1:0]       w_ring_cur;
    logic [D-1:0]       w_ring_new;
    logic [DELAY_W-1:0] w_cfg_delay;
    logic [SYN_W-1:0]   w_cfg_first;
    logic [CNT_W-1:0]   w_cfg_cnt;
    logic [SYN_W-1:0]   w_end;
    logic [DELAY_W-1:0] w_bit;
    logic               w_proc;
    logic               w_ring_we;
    logic               w_emit;
    logic               w_coll;

    // A multi-synapse beat leaves a one-cycle bubble behind it before the pipeline advances again
    assign w_ready    = i_syn_rdy && !(o_syn_vld && (o_syn_start != o_syn_end));
    assign w_clr_req  = i_clear_act || i_clear_config;
    assign w_clearing = (r_clr_state != CLR_IDLE);
    assign w_sweep    = (r_clr_state == CLR_SWEEP);

    assign o_axon_rdy   = w_ready && i_enable && !w_clearing && !w_clr_req && !i_reset;
    assign w_spike_go   = i_axon_vld && o_axon_rdy;
    assign w_scan_go    = !w_spike_go && w_ready && i_enable && !w_clearing && !w_clr_req
                          && !r_scan_done && !i_next_step;
    assign w_issue      = w_spike_go || w_scan_go;
    assign w_issue_addr = w_spike_go ? i_axon_addr : r_scan_idx;
    // While stalled, keep re-reading the held item so its RAM data stays valid
    assign w_rd_addr    = w_ready ? w_issue_addr : r_p_addr;

    dp_ram_param #(.WIDTH(L_CFG_W), .DEPTH(NUM_NEURONS), .AW(ADDR_W)) u_cfg_ram (
        .i_clk   (i_clk),
        .i_we    (w_sweep ? r_clr_cfg : (i_config_we && !w_clearing)),
        .i_waddr (w_sweep ? r_clr_idx : i_config_addr),
        .i_wdata (w_sweep ? '0 : i_config_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_cfg_rdata)
    );

    dp_ram_param #(.WIDTH(D), .DEPTH(NUM_NEURONS), .AW(ADDR_W)) u_ring_ram (
        .i_clk   (i_clk),
        .i_we    (w_sweep || w_ring_we),
        .i_waddr (w_sweep ? r_clr_idx : r_p_addr),
        .i_wdata (w_sweep ? '0 : w_ring_new),
        .i_raddr (w_rd_addr),
        .o_rdata (w_ring_rdata)
    );

    assign w_cfg_delay = w_cfg_rdata[L_CFG_W-1 -: DELAY_W];
    assign w_cfg_first = w_cfg_rdata[SYN_W+CNT_W-1 -: SYN_W];
    assign w_cfg_cnt   = w_cfg_rdata[CNT_W-1:0];
    assign w_end       = w_cfg_first + SYN_W'(w_cfg_cnt) - SYN_W'(1);
    assign w_ring_cur  = (r_wr_vld && (r_wr_addr == r_p_addr)) ? r_wr_data : w_ring_rdata;
    assign w_proc      = r_p_vld && w_ready && !w_clearing;

    always_comb begin
        w_bit      = r_p_scan ? r_p_tptr : (r_p_tptr + w_cfg_delay);
        w_ring_new = w_ring_cur;
        w_ring_we  = 1'b0;
        w_emit     = 1'b0;
        w_coll     = 1'b0;
        if (w_proc) begin
            if (r_p_scan) begin
                if (w_ring_cur[w_bit]) begin
                    w_ring_new[w_bit] = 1'b0;
                    w_ring_we         = 1'b1;
                    w_emit            = 1'b1;
                end
            end else if (w_cfg_delay == '0) begin
                w_emit = 1'b1;
            end else begin
                w_ring_new[w_bit] = 1'b1;
                w_ring_we         = 1'b1;
                w_coll            = w_ring_cur[w_bit];
            end
        end
        if (w_cfg_cnt == '0) begin
            w_emit = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tptr       <= '0;
            r_scan_idx   <= '0;
            r_scan_done  <= 1'b0;
            r_p_vld      <= 1'b0;
            r_p_scan     <= 1'b0;
            r_p_addr     <= '0;
            r_p_tptr     <= '0;
            r_q_vld      <= 1'b0;
            r_q_start    <= '0;
            r_q_end      <= '0;
            r_wr_vld     <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            o_syn_vld    <= 1'b0;
            o_syn_start  <= '0;
            o_syn_end    <= '0;
            o_step_done  <= 1'b0;
            o_coll_count <= '0;
        end else begin
            r_wr_vld  <= w_ring_we;
            r_wr_addr <= r_p_addr;
            r_wr_data <= w_ring_new;
            if (w_coll && (o_coll_count != '1)) begin
                o_coll_count <= o_coll_count + COLL_W'(1);
            end
            if (w_clearing || w_clr_req) begin
                r_p_vld     <= 1'b0;
                r_q_vld     <= 1'b0;
                o_syn_vld   <= 1'b0;
                r_tptr      <= '0;
                r_scan_idx  <= '0;
                r_scan_done <= 1'b0;
                o_step_done <= 1'b0;
            end else begin
                if (w_ready) begin
                    r_p_vld     <= w_issue;
                    r_p_addr    <= w_issue_addr;
                    r_p_scan    <= w_scan_go;
                    r_p_tptr    <= r_tptr;
                    r_q_vld     <= w_emit;
                    r_q_start   <= w_cfg_first;
                    r_q_end     <= w_end;
                    o_syn_vld   <= r_q_vld;
                    o_syn_start <= r_q_start;
                    o_syn_end   <= r_q_end;
                end else if (o_syn_vld && i_syn_rdy) begin
                    o_syn_vld <= 1'b0;
                end
                if (i_next_step) begin
                    r_tptr      <= r_tptr + DELAY_W'(1);
                    r_scan_idx  <= '0;
                    r_scan_done <= 1'b0;
                end else if (w_scan_go) begin
                    if (r_scan_idx == ADDR_W'(NUM_NEURONS - 1)) begin
                        r_scan_done <= 1'b1;
                    end else begin
                        r_scan_idx <= r_scan_idx + ADDR_W'(1);
                    end
                end
                o_step_done <= !i_next_step && r_scan_done && !r_p_vld && !r_q_vld
                               && !o_syn_vld && !i_axon_vld && w_ready;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clr_state  <= CLR_IDLE;
            r_clr_cfg    <= 1'b0;
            r_clr_idx    <= '0;
            o_clear_done <= 1'b0;
        end else begin
            case (r_clr_state)
                CLR_IDLE: begin
                    if (w_clr_req) begin
                        r_clr_state <= CLR_SWEEP;
                        r_clr_idx   <= '0;
                        r_clr_cfg   <= i_clear_config;
                    end
                end
                CLR_SWEEP: begin
                    if (r_clr_idx == ADDR_W'(NUM_NEURONS - 1)) begin
                        r_clr_state  <= CLR_DONE;
                        o_clear_done <= 1'b1;
                    end else begin
                        r_clr_idx <= r_clr_idx + ADDR_W'(1);
                    end
                end
                CLR_DONE: begin
                    if (!w_clr_req) begin
                        r_clr_state  <= CLR_IDLE;
                        o_clear_done <= 1'b0;
                    end
                end
                default: begin
                    r_clr_state  <= CLR_IDLE;
                    o_clear_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ucaspian_axon_ring.sv
// tb/tb_ucaspian_axon_ring.sv - directed self-checking bench for ucaspian_axon_ring
module tb_ucaspian_axon_ring;
    import ucaspian_pkg::*;

    localparam int N = 256;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear_act = 1'b0;
    logic        clear_config = 1'b0;
    logic        clear_done;
    logic [7:0]  config_addr = '0;
    logic [23:0] config_data = '0;
    logic        config_we = 1'b0;
    logic        next_step = 1'b0;
    logic        step_done;
    logic [7:0]  axon_addr = '0;
    logic        axon_vld = 1'b0;
    logic        axon_rdy;
    logic [11:0] syn_start;
    logic [11:0] syn_end;
    logic        syn_vld;
    logic        syn_rdy = 1'b1;
    logic [15:0] coll_count;

    ucaspian_axon_ring dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_enable       (enable),
        .i_clear_act    (clear_act),
        .i_clear_config (clear_config),
        .o_clear_done   (clear_done),
        .i_config_addr  (config_addr),
        .i_config_data  (config_data),
        .i_config_we    (config_we),
        .i_next_step    (next_step),
        .o_step_done    (step_done),
        .i_axon_addr    (axon_addr),
        .i_axon_vld     (axon_vld),
        .o_axon_rdy     (axon_rdy),
        .o_syn_start    (syn_start),
        .o_syn_end      (syn_end),
        .o_syn_vld      (syn_vld),
        .i_syn_rdy      (syn_rdy),
        .o_coll_count   (coll_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] s;
        logic [11:0] e;
        logic [15:0] step;
    } beat_t;

    beat_t beats[$];
    int    cur_step = 0;
    int    n_checks = 0;
    int    n_pass = 0;

    always @(negedge clk) begin
        if (!reset && syn_vld && syn_rdy) begin
            beats.push_back({syn_start, syn_end, 16'(cur_step)});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    function automatic logic [31:0] beat_s(input int i);
        return (i < beats.size()) ? 32'(beats[i].s) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] beat_e(input int i);
        return (i < beats.size()) ? 32'(beats[i].e) : 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] beat_step(input int i);
        return (i < beats.size()) ? 32'(beats[i].step) : 32'hFFFF_FFFF;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int a, input int d, input int first, input int cnt);
        axon_cfg_t c;
        c.delay     = 4'(d);
        c.first_syn = 12'(first);
        c.syn_count = 8'(cnt);
        config_addr = 8'(a);
        config_data = c;
        config_we   = 1'b1;
        tick();
        config_we   = 1'b0;
    endtask

    task automatic spike(input int a);
        bit ok;
        ok = 1'b0;
        axon_addr = 8'(a);
        axon_vld  = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = axon_rdy;
            tick();
        end
        axon_vld = 1'b0;
        if (!ok) check("spike_accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            ok = step_done;
            if (!ok) tick();
        end
        tick();
        if (!ok) check("step_done_timeout", 0, 1);
    endtask

    task automatic pulse_step();
        next_step = 1'b1;
        cur_step++;
        tick();
        next_step = 1'b0;
    endtask

    task automatic advance();
        wait_done();
        pulse_step();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  s0;
        int  first_k;
        bit  ok;
        bit  seen_done;

        repeat (3) tick();
        @(negedge clk);
        check("rst_syn_vld", syn_vld, 0);
        check("rst_syn_start", syn_start, 0);
        check("rst_syn_end", syn_end, 0);
        check("rst_step_done", step_done, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_coll", coll_count, 0);
        tick();
        reset = 1'b0;

        clear_config = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 600 && !ok; k++) begin
            @(negedge clk);
            ok = clear_done;
            tick();
        end
        check("init_clear_done", ok, 1);
        clear_config = 1'b0;
        tick();
        tick();
        enable = 1'b1;

        cfg(5, 0, 100, 4);
        cfg(7, 3, 10, 1);
        cfg(9, 0, 4094, 4);
        cfg(11, 0, 500, 0);
        cfg(20, 1, 200, 3);
        cfg(30, 1, 300, 2);
        cfg(40, 1, 400, 1);

        // zero-delay latency: syn_vld on the third cycle after the handshake
        beats.delete();
        axon_addr = 8'd5;
        axon_vld  = 1'b1;
        @(negedge clk);
        check("lat_axon_rdy", axon_rdy, 1);
        tick();
        axon_vld = 1'b0;
        @(negedge clk);
        check("lat_cycle1", syn_vld, 0);
        tick();
        @(negedge clk);
        check("lat_cycle2", syn_vld, 0);
        tick();
        @(negedge clk);
        check("lat_cycle3", syn_vld, 1);
        check("lat_start", syn_start, 100);
        check("lat_end", syn_end, 103);
        repeat (4) tick();
        check("lat_beats", beats.size(), 1);

        beats.delete();
        spike(11);
        repeat (8) tick();
        check("cnt0_no_beat", beats.size(), 0);
        spike(9);
        repeat (8) tick();
        check("wrap_beats", beats.size(), 1);
        check("wrap_start", beat_s(0), 4094);
        check("wrap_end", beat_e(0), 1);

        // d=3 neuron fires only during the scan three steps later
        beats.delete();
        s0 = cur_step;
        spike(7);
        repeat (5) advance();
        check("delay_beats", beats.size(), 1);
        check("delay_step", beat_step(0), s0 + 3);
        check("delay_start", beat_s(0), 10);
        check("delay_end", beat_e(0), 10);

        beats.delete();
        s0 = cur_step;
        check("coll_before", coll_count, 0);
        spike(7);
        spike(7);
        repeat (4) tick();
        check("coll_after", coll_count, 1);
        repeat (4) advance();
        check("coll_beats", beats.size(), 1);
        check("coll_step", beat_step(0), s0 + 3);

        // back-to-back spikes on neuron 7 with delay changed from 3 to 5 in between
        beats.delete();
        s0 = cur_step;
        axon_addr   = 8'd7;
        axon_vld    = 1'b1;
        config_addr = 8'd7;
        config_data = {4'd5, 12'd10, 8'd1};
        config_we   = 1'b1;
        @(negedge clk);
        check("fwd_rdy_a", axon_rdy, 1);
        tick();
        config_we = 1'b0;
        @(negedge clk);
        check("fwd_rdy_b", axon_rdy, 1);
        tick();
        axon_vld = 1'b0;
        repeat (6) advance();
        check("fwd_beats", beats.size(), 2);
        check("fwd_step_a", beat_step(0), s0 + 3);
        check("fwd_step_b", beat_step(1), s0 + 5);
        check("fwd_coll", coll_count, 1);

        // backpressure across a scan with three pending neurons
        beats.delete();
        s0 = cur_step;
        spike(20);
        spike(30);
        spike(40);
        wait_done();
        syn_rdy = 1'b0;
        pulse_step();
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seen_done |= step_done;
            tick();
        end
        check("bp_no_done", seen_done, 0);
        check("bp_no_beats", beats.size(), 0);
        syn_rdy = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 2000 && !ok; k++) begin
            @(negedge clk);
            ok = step_done;
            if (!ok) tick();
        end
        check("bp_done_seen", ok, 1);
        check("bp_beats_at_done", beats.size(), 3);
        tick();
        check("bp_s0", beat_s(0), 200);
        check("bp_e0", beat_e(0), 202);
        check("bp_s1", beat_s(1), 300);
        check("bp_e1", beat_e(1), 301);
        check("bp_s2", beat_s(2), 400);
        check("bp_e2", beat_e(2), 400);
        check("bp_step", beat_step(2), s0 + 1);

        // clear_act early in a step that has neuron 20 pending
        spike(20);
        advance();
        beats.delete();
        clear_act = 1'b1;
        first_k = -1;
        for (int k = 1; k <= N + 10; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (clear_done && first_k < 0) first_k = k;
        end
        check("clr_done_cycle", first_k, N + 1);
        check("clr_done_hold", clear_done, 1);
        check("clr_axon_rdy", axon_rdy, 0);
        tick();
        clear_act = 1'b0;
        tick();
        @(negedge clk);
        check("clr_done_drop", clear_done, 0);
        tick();
        cur_step = 0;
        repeat (3) advance();
        check("clr_no_beats", beats.size(), 0);

        // reset while a zero-delay spike is in flight
        beats.delete();
        spike(5);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (6) tick();
        check("rst_mid_no_beat", beats.size(), 0);
        check("rst_mid_coll", coll_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
